// File: rtl/grant_pkg.sv
// Shared types and helpers for the grant/ownership stage that sits behind the
// 4-way fixed-priority arbiter.
package grant_pkg;

  typedef enum logic [1:0] {IDLE, OWN, TURN} gh_state_t;

  localparam int N_REQ_DEF = 4;

  function automatic logic [1:0] onehot_to_idx(input logic [N_REQ_DEF-1:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < N_REQ_DEF; i++)
      if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [N_REQ_DEF-1:0] keep_msb(input logic [N_REQ_DEF-1:0] v);
    logic [N_REQ_DEF-1:0] r;
    r = '0;
    for (int i = 0; i < N_REQ_DEF; i++)
      if (v[i]) r = N_REQ_DEF'(1) << i;
    return r;
  endfunction

endpackage

// File: rtl/grant_hold_ctrl.sv
// Bus-ownership lock behind the fixed-priority arbiter: latch the winner, hold
// until release, insert a turnaround gap. Optional owner timeout: GRANT_TIMEOUT_EN.
//
// state | meaning
// IDLE  | arbiter enabled, waiting for a grant
// OWN   | owner latched, waiting for done / dropped req (or timeout)
// TURN  | turnaround gap after release, arbiter disabled
module grant_hold_ctrl
  import grant_pkg::*;
#(
  parameter int N_REQ    = N_REQ_DEF,
  parameter int MAX_HOLD = 16,
  parameter int GAP      = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [N_REQ-1:0] req,
  input  logic [N_REQ-1:0] arb_gnt,
  input  logic [N_REQ-1:0] done,
  output logic             arb_en,
  output logic [N_REQ-1:0] owner,
  output logic             owner_vld,
  output logic [1:0]       owner_id,
  output logic             timeout
);

  if (N_REQ != N_REQ_DEF || MAX_HOLD < 1 || MAX_HOLD > 255 || GAP < 0 || GAP > 15) begin : g_bad_param
    $error("grant_hold_ctrl: parameter out of range");
  end

  gh_state_t  state;
  logic [3:0] gap_cnt;
  logic       release_now;
`ifdef GRANT_TIMEOUT_EN
  logic [7:0] hold_cnt;
`endif

  assign arb_en      = en && (state == IDLE);
  assign release_now = done[owner_id] || !req[owner_id];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      owner     <= '0;
      owner_vld <= 1'b0;
      owner_id  <= 2'd0;
      timeout   <= 1'b0;
      gap_cnt   <= 4'd0;
`ifdef GRANT_TIMEOUT_EN
      hold_cnt  <= 8'd0;
`endif
    end else begin
      timeout <= 1'b0;
      if (!en) begin
        state     <= IDLE;
        owner     <= '0;
        owner_vld <= 1'b0;
        owner_id  <= 2'd0;
        gap_cnt   <= 4'd0;
      end else begin
        case (state)
          IDLE: begin
            if (|arb_gnt) begin
              owner     <= keep_msb(arb_gnt);
              owner_id  <= onehot_to_idx(arb_gnt);
              owner_vld <= 1'b1;
              state     <= OWN;
`ifdef GRANT_TIMEOUT_EN
              hold_cnt  <= 8'd0;
`endif
            end
          end
          OWN: begin
`ifdef GRANT_TIMEOUT_EN
            if (hold_cnt != 8'hff) hold_cnt <= hold_cnt + 8'd1;
`endif
            // Release takes priority over a coincident timeout.
            if (release_now) begin
              owner     <= '0;
              owner_vld <= 1'b0;
              owner_id  <= 2'd0;
              gap_cnt   <= 4'd0;
              state     <= (GAP > 0) ? TURN : IDLE;
            end
`ifdef GRANT_TIMEOUT_EN
            else if (hold_cnt == 8'(MAX_HOLD - 1)) begin
              timeout   <= 1'b1;
              owner     <= '0;
              owner_vld <= 1'b0;
              owner_id  <= 2'd0;
              gap_cnt   <= 4'd0;
              state     <= (GAP > 0) ? TURN : IDLE;
            end
`endif
          end
          TURN: begin
            if (gap_cnt == 4'(GAP - 1)) begin
              gap_cnt <= 4'd0;
              state   <= IDLE;
            end else begin
              gap_cnt <= gap_cnt + 4'd1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
